credit_bank: RTL and testbench



---
 rtl/credit_bank.sv | 113 +++++++++++
 tb/tb_credit_bank.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/credit_bank.sv
// Credit ledger and spin sequencer for the slot-machine number block.
// Optional `CREDIT_BANK_FREEPLAY_EN: a press while broke reloads START_CREDITS and plays.
module credit_bank #(
    parameter int START_CREDITS = 10,
    parameter int SPIN_COST     = 1,
    parameter int MAX_CREDITS   = 99,
    parameter int ROUND_CYCLES  = 4900,
    parameter int SAMPLE_AT     = 2100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       button,
    input  logic [3:0] score,
    output logic       spin,
    output logic       busy,
    output logic       broke,
    output logic [3:0] last_win,
    output logic [3:0] credits_tens,
    output logic [3:0] credits_ones
);

    localparam int CNT_W = (ROUND_CYCLES > 2) ? $clog2(ROUND_CYCLES) : 1;
    localparam logic [6:0]       START_C    = 7'(START_CREDITS);
    localparam logic [6:0]       COST_C     = 7'(SPIN_COST);
    localparam logic [6:0]       MAX_C      = 7'(MAX_CREDITS);
    localparam logic [CNT_W-1:0] SAMPLE_IDX = CNT_W'(SAMPLE_AT);
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(ROUND_CYCLES - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state;
    logic [2:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic [6:0]       r_credits;
    logic             r_spin;
    logic [3:0]       r_last_win;
    logic             w_press;

    // Payout is summed at 8 bits so an oversized score cannot wrap before the clamp.
    function automatic logic [6:0] sat_add(input logic [6:0] c, input logic [3:0] s);
        logic [7:0] sum;
        sum = {1'b0, c} + {4'b0000, s};
        return (sum > {1'b0, MAX_C}) ? MAX_C : sum[6:0];
    endfunction

    function automatic logic [6:0] sub_cost(input logic [6:0] c);
        return (c >= COST_C) ? (c - COST_C) : c;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[1:0], button};
        end
    end

    assign w_press = r_sync[1] & ~r_sync[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_spin     <= 1'b0;
            r_cnt      <= '0;
            r_credits  <= START_C;
            r_last_win <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_press) begin
                        if (r_credits >= COST_C) begin
                            r_credits <= sub_cost(r_credits);
                            r_cnt     <= '0;
                            r_spin    <= 1'b1;
                            r_state   <= S_RUN;
                        end
`ifdef CREDIT_BANK_FREEPLAY_EN
                        else begin
                            r_credits <= sub_cost(START_C);
                            r_cnt     <= '0;
                            r_spin    <= 1'b1;
                            r_state   <= S_RUN;
                        end
`endif
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == SAMPLE_IDX) begin
                        r_last_win <= score;
                        r_credits  <= sat_add(r_credits, score);
                    end
                    if (r_cnt == LAST_IDX) begin
                        r_spin  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_spin  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign spin         = r_spin;
    assign busy         = r_spin;
    assign broke        = (r_credits < COST_C);
    assign last_win     = r_last_win;
    assign credits_tens = 4'(r_credits / 7'd10);
    assign credits_ones = 4'(r_credits % 7'd10);

endmodule

// File: tb/tb_credit_bank.sv
// Scoreboard bench for credit_bank: per-round expectations are queued at press time.
module tb_credit_bank;

    localparam int RC    = 20;
    localparam int SA    = 10;
    localparam int START = 10;
    localparam int MAXC  = 99;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       button;
    logic [3:0] score;
    logic       spin, busy, broke;
    logic [3:0] last_win, credits_tens, credits_ones;

    always #5 clk = ~clk;

    credit_bank #(
        .START_CREDITS(START),
        .SPIN_COST    (1),
        .MAX_CREDITS  (MAXC),
        .ROUND_CYCLES (RC),
        .SAMPLE_AT    (SA)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .button      (button),
        .score       (score),
        .spin        (spin),
        .busy        (busy),
        .broke       (broke),
        .last_win    (last_win),
        .credits_tens(credits_tens),
        .credits_ones(credits_ones)
    );

    typedef struct {
        int rise;
        int high;
        int cred_start;
        int cred_pre;
        int cred_paid;
        int win;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_credits;
    int   m_win;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic int bal();
        return int'(credits_tens) * 10 + int'(credits_ones);
    endfunction

    task automatic push_round(input int sc);
        exp_t e;
        bit   start;
        start = 1'b0;
        if (m_credits >= 1) begin
            m_credits = m_credits - 1;
            start = 1'b1;
        end
`ifdef CREDIT_BANK_FREEPLAY_EN
        else begin
            m_credits = START - 1;
            start = 1'b1;
        end
`endif
        if (start) begin
            e.rise       = 3;
            e.high       = RC;
            e.cred_start = m_credits;
            e.cred_pre   = m_credits;
            m_credits    = (m_credits + sc > MAXC) ? MAXC : m_credits + sc;
            m_win        = sc;
            e.cred_paid  = m_credits;
            e.win        = m_win;
        end else begin
            e.rise       = 0;
            e.high       = 0;
            e.cred_start = m_credits;
            e.cred_pre   = m_credits;
            e.cred_paid  = m_credits;
            e.win        = m_win;
        end
        sb.push_back(e);
    endtask

    // hold: negedge index where the button is released; repress: re-press index (0 = none);
    // start_now: button already raised by the previous round; chain: raise button as spin falls.
    task automatic run_round(input int sc, input int hold, input int repress,
                             input bit start_now, input bit chain);
        exp_t e;
        int   rise, high, cs, cp, cpaid, w, busy_bad, limit;
        bit   prev, done;
        rise = 0; high = 0; cs = -1; cp = -1; cpaid = -1; w = -1; busy_bad = 0;
        prev = 1'b0; done = 1'b0;
        limit = ((hold > repress + 3) ? hold : repress + 3) + RC + 8;
        push_round(sc);
        score = 4'(sc);
        if (!start_now) begin
            @(negedge clk);
            button = 1'b1;
        end
        for (int i = 1; i <= limit && !done; i++) begin
            @(negedge clk);
            if (i == hold) button = 1'b0;
            if (repress != 0 && i == repress) button = 1'b1;
            if (repress != 0 && i == repress + 3) button = 1'b0;
            if (busy !== spin) busy_bad++;
            if (spin) begin
                high++;
                if (rise == 0) begin
                    rise = i;
                    cs = bal();
                end
            end
            if (rise != 0 && i == rise + SA) cp = bal();
            if (rise != 0 && i == rise + SA + 1) begin
                cpaid = bal();
                w = int'(last_win);
            end
            if (chain && prev && !spin) begin
                button = 1'b1;
                done = 1'b1;
            end
            prev = spin;
        end
        if (!chain) button = 1'b0;
        if (rise == 0) begin
            cs = bal();
            cp = cs;
            cpaid = cs;
            w = int'(last_win);
        end
        if (sb.size() == 0) begin
            check("sb_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            check("rise_latency", rise, e.rise);
            check("spin_len", high, e.high);
            check("cred_after_cost", cs, e.cred_start);
            check("cred_before_pay", cp, e.cred_pre);
            check("cred_after_pay", cpaid, e.cred_paid);
            check("last_win", w, e.win);
            check("busy_eq_spin", busy_bad, 0);
            check("broke", int'(broke), (m_credits < 1) ? 1 : 0);
        end
    endtask

    task automatic reset_mid(input int sc);
        int spun;
        score = 4'(sc);
        @(negedge clk);
        button = 1'b1;
        for (int k = 0; k < 10 && !spin; k++) begin
            @(negedge clk);
            button = 1'b0;
        end
        button = 1'b0;
        check("rst_round_started", int'(spin), 1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_credits = START;
        m_win = 0;
        check("rst_spin_async", int'(spin), 0);
        check("rst_busy_async", int'(busy), 0);
        check("rst_credits", bal(), m_credits);
        @(negedge clk);
        rst_n = 1'b1;
        spun = 0;
        repeat (15) begin
            @(negedge clk);
            if (spin) spun++;
        end
        check("rst_no_spin", spun, 0);
        check("rst_no_payout", bal(), m_credits);
        check("rst_last_win", int'(last_win), m_win);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        button = 1'b0;
        score  = 4'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_spin", int'(spin), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_last_win", int'(last_win), 0);
        check("reset_tens", int'(credits_tens), 1);
        check("reset_ones", int'(credits_ones), 0);
        check("reset_broke", int'(broke), 0);
        m_credits = START;
        m_win = 0;

        run_round(5, 2, 0, 1'b0, 1'b0);
        run_round(0, 60, 0, 1'b0, 1'b0);
        run_round(3, 2, 8, 1'b0, 1'b0);
        run_round(10, 2, 0, 1'b0, 1'b1);
        run_round(10, 2, 0, 1'b1, 1'b0);
        for (int r = 0; r < 7; r++) run_round(10, 2, 0, 1'b0, 1'b0);
        run_round(3, 2, 0, 1'b0, 1'b0);
        check("bal_98", bal(), 98);
        run_round(10, 2, 0, 1'b0, 1'b0);
        check("sat_tens", int'(credits_tens), 9);
        check("sat_ones", int'(credits_ones), 9);
        run_round(15, 2, 0, 1'b0, 1'b0);

        reset_mid(7);

        for (int r = 0; r < 10; r++) run_round(0, 2, 0, 1'b0, 1'b0);
        check("drained_bal", bal(), 0);
        check("drained_broke", int'(broke), 1);
        run_round(4, 2, 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
